if_unit: RTL and testbench

// - Instruction-fetch stage of the 5-stage LoongArch pipeline, directly upstream of the ID stage.
// - Generates the sequential PC and redirects to the branch target signalled by ID on br_bus.
// - Fetches over an SRAM-like instruction port (req/addr_ok/data_ok) with one request outstanding.
// - Delivers {pc, inst} to ID through a valid/allow-in handshake, and drops wrong-path fetches.

---
 rtl/if_unit.sv | 164 ++++++++++++++++
 tb/tb_if_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_unit.sv
// rtl/if_unit.sv - LoongArch instruction-fetch stage: sequential PC, branch redirect, SRAM-like fetch.
// Define IF_SKID_BUF_EN to add a one-entry skid buffer behind the ID output slot.
module if_unit #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ID_Allow_in,
  output logic        IF_to_ID_Valid,
  output logic [63:0] IF_to_ID_Bus,
  input  logic [33:0] br_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] seq_pc_q, seq_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        cancel_q, cancel_d;
  logic        slot_valid_q, slot_valid_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic [31:0] slot_inst_q, slot_inst_d;
`ifdef IF_SKID_BUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
`endif

  logic        br_taken;
  logic [31:0] br_target;
  logic        unused_stall;
  logic        consume;
  logic        req_ok;
  logic        addr_hs;
  logic        data_ret;

  assign br_taken     = br_bus[33];
  assign br_target    = br_bus[32:1];
  assign unused_stall = br_bus[0];
  assign consume      = slot_valid_q & ID_Allow_in;

`ifdef IF_SKID_BUF_EN
  assign req_ok = !buf_valid_q;
`else
  assign req_ok = !slot_valid_q | consume;
`endif

  // Gated by resetn so the request drops the moment reset is asserted.
  assign inst_sram_req   = resetn & (state_q == S_REQ) & req_ok;
  assign inst_sram_addr  = seq_pc_q;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0;
  assign addr_hs         = inst_sram_req & inst_sram_addr_ok;
  assign data_ret        = (state_q == S_WAIT) & inst_sram_data_ok;

  assign IF_to_ID_Valid = slot_valid_q;
  assign IF_to_ID_Bus   = {slot_pc_q, slot_inst_q};

  always_comb begin
    state_d      = state_q;
    seq_pc_d     = seq_pc_q;
    req_pc_d     = req_pc_q;
    cancel_d     = cancel_q;
    slot_valid_d = slot_valid_q;
    slot_pc_d    = slot_pc_q;
    slot_inst_d  = slot_inst_q;
`ifdef IF_SKID_BUF_EN
    buf_valid_d  = buf_valid_q;
    buf_pc_d     = buf_pc_q;
    buf_inst_d   = buf_inst_q;
`endif

    if (state_q == S_REQ) begin
      if (addr_hs) begin
        state_d  = S_WAIT;
        req_pc_d = seq_pc_q;
        seq_pc_d = seq_pc_q + 32'd4;
      end
    end else if (inst_sram_data_ok) begin
      state_d = S_REQ;
    end

    if (consume) begin
`ifdef IF_SKID_BUF_EN
      slot_valid_d = buf_valid_q;
      slot_pc_d    = buf_pc_q;
      slot_inst_d  = buf_inst_q;
      buf_valid_d  = 1'b0;
`else
      slot_valid_d = 1'b0;
`endif
    end

    // slot_valid_d already reflects this cycle's consume/refill.
    if (data_ret) begin
      if (cancel_q) begin
        cancel_d = 1'b0;
      end else if (!slot_valid_d) begin
        slot_valid_d = 1'b1;
        slot_pc_d    = req_pc_q;
        slot_inst_d  = inst_sram_rdata;
      end
`ifdef IF_SKID_BUF_EN
      else begin
        buf_valid_d = 1'b1;
        buf_pc_d    = req_pc_q;
        buf_inst_d  = inst_sram_rdata;
      end
`endif
    end

    if (br_taken) begin
      seq_pc_d     = br_target;
      slot_valid_d = 1'b0;
`ifdef IF_SKID_BUF_EN
      buf_valid_d  = 1'b0;
`endif
      cancel_d     = ((state_q == S_WAIT) & !inst_sram_data_ok) |
                     ((state_q == S_REQ) & addr_hs);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_REQ;
      seq_pc_q     <= RESET_PC;
      req_pc_q     <= 32'h0;
      cancel_q     <= 1'b0;
      slot_valid_q <= 1'b0;
      slot_pc_q    <= 32'h0;
      slot_inst_q  <= 32'h0;
`ifdef IF_SKID_BUF_EN
      buf_valid_q  <= 1'b0;
      buf_pc_q     <= 32'h0;
      buf_inst_q   <= 32'h0;
`endif
    end else begin
      state_q      <= state_d;
      seq_pc_q     <= seq_pc_d;
      req_pc_q     <= req_pc_d;
      cancel_q     <= cancel_d;
      slot_valid_q <= slot_valid_d;
      slot_pc_q    <= slot_pc_d;
      slot_inst_q  <= slot_inst_d;
`ifdef IF_SKID_BUF_EN
      buf_valid_q  <= buf_valid_d;
      buf_pc_q     <= buf_pc_d;
      buf_inst_q   <= buf_inst_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_unit.sv
// tb/tb_if_unit.sv - randomized scoreboard bench for if_unit with an SRAM responder model.
module tb_if_unit;
  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ID_Allow_in;
  logic        IF_to_ID_Valid;
  logic [63:0] IF_to_ID_Bus;
  logic [33:0] br_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  if_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .resetn(resetn),
    .ID_Allow_in(ID_Allow_in), .IF_to_ID_Valid(IF_to_ID_Valid), .IF_to_ID_Bus(IF_to_ID_Bus),
    .br_bus(br_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Reference: ID must see a contiguous +4 PC stream from the last redirect target (or RESET_PC).
  logic [31:0] exp_pc_q[$];

  task automatic refill(input logic [31:0] start);
    logic [31:0] p;
    p = start;
    exp_pc_q.delete();
    for (int i = 0; i < 1024; i++) begin
      exp_pc_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } pend_t;
  pend_t pend_q[$];

  int          cyc = 0;
  logic [31:0] exp_addr;
  int          hs_count = 0;
  int          deliveries = 0;
  int          p_addr_ok = 100, p_data = 100, p_allow = 100, p_br = 0;
  int          lat_min = 1, lat_max = 1;
  logic [31:0] br_target_next = 32'h1c000100;
  bit          force_br_now = 0;
  bit          force_br_valid = 0;
  bit          force_hs_en = 0;
  logic [31:0] force_hs_addr = 32'h0;
  bit          release_now = 0;

  // Monitor: pops the expected stream on every transfer ID actually accepts.
  bit br_prev = 0;
  always @(negedge clk) begin
    logic [31:0] e;
    #4;
    if (resetn) begin
      if (br_prev) check("flush_valid", {63'd0, IF_to_ID_Valid}, 64'd0);
      if (IF_to_ID_Valid && ID_Allow_in && !br_bus[33]) begin
        if (exp_pc_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL deliver_unexpected: got pc %h expected none", IF_to_ID_Bus[63:32]);
        end else begin
          e = exp_pc_q.pop_front();
          check("deliver_pc", {32'd0, IF_to_ID_Bus[63:32]}, {32'd0, e});
          check("deliver_inst", {32'd0, IF_to_ID_Bus[31:0]}, {32'd0, mem_word(e)});
          deliveries++;
        end
      end
      br_prev = br_bus[33];
    end else begin
      br_prev = 0;
    end
  end

  task automatic step();
    bit          hs, take_br, stale;
    logic [31:0] a;
    int          lat;
    @(negedge clk);
    cyc++;
    stale = 0;
    if (release_now) begin
      resetn = 1'b1;
      release_now = 0;
      stale = 1;
    end
    if (stale) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = 32'hDEADBEEF;
    end else if (pend_q.size() > 0 && pend_q[0].ready <= cyc && $urandom_range(99) < p_data) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = $urandom;
    end
    ID_Allow_in = ($urandom_range(99) < p_allow);
    br_bus = {1'b0, 32'($urandom), 1'($urandom)};
    #1;
    if (stale) check("first_req_after_release", {63'd0, inst_sram_req}, 64'd1);
    inst_sram_addr_ok = ($urandom_range(99) < p_addr_ok);
    hs = inst_sram_req & inst_sram_addr_ok;
    take_br = (p_br > 0) && ($urandom_range(99) < p_br);
    if (force_br_now) begin take_br = 1; force_br_now = 0; end
    if (force_br_valid && IF_to_ID_Valid && ID_Allow_in) begin take_br = 1; force_br_valid = 0; end
    if (force_hs_en && hs && inst_sram_addr == force_hs_addr) begin take_br = 1; force_hs_en = 0; end
    if (hs) begin
      a = inst_sram_addr;
      check("req_addr", {32'd0, a}, {32'd0, exp_addr});
      exp_addr = a + 32'd4;
      hs_count++;
      lat = int'($urandom_range(lat_max, lat_min));
      pend_q.push_back('{addr: a, ready: cyc + lat});
    end
    if (take_br) begin
      br_bus   = {1'b1, br_target_next, 1'($urandom)};
      exp_addr = br_target_next;
      refill(br_target_next);
    end
    #1;
  endtask

  task automatic model_reset();
    pend_q.delete();
    exp_addr = RESET_PC;
    refill(RESET_PC);
  endtask

  initial begin
    int hs0, guard;
    resetn = 1'b0;
    ID_Allow_in = 1'b0;
    br_bus = 34'd0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", {63'd0, IF_to_ID_Valid}, 64'd0);
    check("rst_bus", IF_to_ID_Bus, 64'd0);
    check("rst_req", {63'd0, inst_sram_req}, 64'd0);
    check("tied_outs", {25'd0, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
          {25'd0, 1'b0, 2'b10, 4'b0000, 32'h0});

    // Back-to-back streaming from reset.
    release_now = 1;
    repeat (20) step();

    // ID stalls: IF must fill up, stop requesting, and lose nothing.
    p_allow = 0;
    hs0 = hs_count;
    repeat (20) step();
    check("stall_no_req", {63'd0, inst_sram_req}, 64'd0);
`ifdef IF_SKID_BUF_EN
    check("stall_hs_bound", {63'd0, (hs_count - hs0) <= 2}, 64'd1);
`else
    check("stall_hs_bound", {63'd0, (hs_count - hs0) <= 1}, 64'd1);
`endif
    p_allow = 100;
    repeat (20) step();

    // Redirect while waiting; the wrong-path data arrives 3 cycles after the branch.
    lat_min = 4; lat_max = 4;
    hs0 = hs_count;
    guard = 0;
    while (hs_count == hs0 && guard < 50) begin step(); guard++; end
    check("wait_hs_seen", {63'd0, hs_count != hs0}, 64'd1);
    br_target_next = 32'h1c000100;
    force_br_now = 1;
    repeat (20) step();
    lat_min = 1; lat_max = 1;

    // Redirect while an instruction is being handed to ID.
    br_target_next = 32'h1c000200;
    force_br_valid = 1;
    repeat (20) step();
    check("br_valid_used", {63'd0, force_br_valid}, 64'd0);

    // Reset during WAIT, stale data_ok after release, then redirect on the 1c000008 handshake.
    lat_min = 3; lat_max = 3;
    guard = 0;
    while (pend_q.size() == 0 && guard < 50) begin step(); guard++; end
    check("reset_in_wait", {63'd0, pend_q.size() > 0}, 64'd1);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, IF_to_ID_Valid}, 64'd0);
    check("async_rst_bus", IF_to_ID_Bus, 64'd0);
    check("async_rst_req", {63'd0, inst_sram_req}, 64'd0);
    model_reset();
    lat_min = 1; lat_max = 1;
    br_target_next = 32'h1c000300;
    force_hs_addr = 32'h1c000008;
    force_hs_en = 1;
    release_now = 1;
    repeat (20) step();
    check("hs_br_used", {63'd0, force_hs_en}, 64'd0);

    // Randomized traffic, including unaligned and wrapping redirect targets.
    p_br = 3;
    for (int seg = 0; seg < 30; seg++) begin
      p_addr_ok = $urandom_range(100, 30);
      p_data    = $urandom_range(100, 40);
      p_allow   = $urandom_range(100, 20);
      lat_max   = $urandom_range(4, 1);
      case (seg % 3)
        0: br_target_next = 32'hFFFFFFF0 + 32'($urandom_range(3, 0) * 4);
        1: br_target_next = $urandom;
        default: br_target_next = 32'h1c000000 | (32'($urandom) & 32'h0000FFFC);
      endcase
      repeat (100) step();
    end

    p_br = 0; p_allow = 100; p_addr_ok = 100; p_data = 100; lat_max = 1;
    repeat (30) step();
    check("progress", {63'd0, deliveries > 300}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
